// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Inhibit/request-to-send, device-clocked frame shift, ack check and timeout.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 2500,
   parameter int TIMEOUT_CYCLES = 375000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_low,
   output logic       ps2_data_low,
   output logic       busy,
   output logic       done,
   output logic       error
);
   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int FW      = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] INH_START = CW'(INHIBIT_CYCLES - 2);
   localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [FW-1:0] F_LAST    = FW'(FILTER_LEN - 1);

   typedef enum logic [2:0] {IDLE, INHIBIT, RELEASE, SHIFT, STOP, ACK, WAIT_IDLE} state_t;

   // index 0 = clock line, index 1 = data line
   logic [1:0]    meta;
   logic [1:0]    sync;
   logic [1:0]    filt;
   logic [FW-1:0] fcnt [2];
   logic          clk_prev;
   logic          clk_fall;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta     <= 2'b11;
         sync     <= 2'b11;
         filt     <= 2'b11;
         fcnt[0]  <= '0;
         fcnt[1]  <= '0;
         clk_prev <= 1'b1;
      end else begin
         meta     <= {ps2_data_in, ps2_clk_in};
         sync     <= meta;
         clk_prev <= filt[0];
         for (int i = 0; i < 2; i++) begin
            if (sync[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == F_LAST) begin
               filt[i] <= sync[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + FW'(1);
            end
         end
      end
   end

   assign clk_fall = clk_prev & ~filt[0];

   state_t        state;
   logic [CW-1:0] cnt;
   logic [8:0]    frame;
   logic [3:0]    nbit;

   assign tx_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         cnt          <= '0;
         frame        <= '0;
         nbit         <= '0;
         ps2_clk_low  <= 1'b0;
         ps2_data_low <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_valid) begin
                  frame       <= {~^tx_data, tx_data};
                  cnt         <= '0;
                  ps2_clk_low <= 1'b1;
                  state       <= INHIBIT;
               end
            end
            INHIBIT: begin
               // start bit goes low in the final inhibit cycle
               if (cnt == INH_START) ps2_data_low <= 1'b1;
               if (cnt == INH_LAST) begin
                  ps2_clk_low <= 1'b0;
                  cnt         <= '0;
                  state       <= RELEASE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            RELEASE: begin
               nbit  <= '0;
               cnt   <= cnt + CW'(1);
               state <= SHIFT;
            end
            default: begin
               cnt <= cnt + CW'(1);
               if (cnt == TO_LAST) begin
                  ps2_clk_low  <= 1'b0;
                  ps2_data_low <= 1'b0;
                  error        <= 1'b1;
                  state        <= IDLE;
               end else begin
                  case (state)
                     SHIFT: begin
                        if (clk_fall) begin
                           if (nbit == 4'd9) begin
                              ps2_data_low <= 1'b0;
                              state        <= STOP;
                           end else begin
                              ps2_data_low <= ~frame[0];
                              frame        <= {1'b0, frame[8:1]};
                              nbit         <= nbit + 4'd1;
                           end
                        end
                     end
                     STOP: state <= ACK;
                     ACK: begin
                        if (clk_fall) begin
                           if (!filt[1]) begin
                              state <= WAIT_IDLE;
                           end else begin
                              error <= 1'b1;
                              state <= IDLE;
                           end
                        end
                     end
                     WAIT_IDLE: begin
                        if (filt == 2'b11) begin
                           done  <= 1'b1;
                           state <= IDLE;
                        end
                     end
                     default: state <= IDLE;
                  endcase
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
   localparam int INH = 2500;
   localparam int TO  = 4000;
   localparam int HP  = 40;

   logic       clk;
   logic       reset_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic       ps2_clk_low;
   logic       ps2_data_low;
   logic       busy;
   logic       done;
   logic       error;
   logic       dev_clk_low;
   logic       dev_data_low;

   int cyc, n_done, n_err, n_bad, err_cyc, rel_cyc;
   int vectors, miscompares;

   // open-drain wired-AND of host and device
   assign ps2_clk_in  = ~(ps2_clk_low | dev_clk_low);
   assign ps2_data_in = ~(ps2_data_low | dev_data_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(8)) dut (
      .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
      .ps2_clk_low(ps2_clk_low), .ps2_data_low(ps2_data_low), .busy(busy),
      .done(done), .error(error)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (done) n_done++;
      if (error) begin
         n_err++;
         err_cyc = cyc;
      end
      if ((done || error) && !tx_ready) n_bad++;
      if (done && error) n_bad++;
   endtask

   // frame bits after the start bit: data LSB first, odd parity, stop
   function automatic logic [9:0] model_bits(input logic [7:0] d);
      logic [9:0] b;
      for (int i = 0; i < 8; i++) b[i] = d[i];
      b[8] = (($countones(d) % 2) == 0);
      b[9] = 1'b1;
      return b;
   endfunction

   task automatic start_tx(input logic [7:0] d);
      int inh, dl;
      check("ready_before", tx_ready, 1);
      tx_data  = d;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      check("busy_after_accept", busy, 1);
      check("clk_low_after_accept", ps2_clk_low, 1);
      inh = 0;
      dl  = 0;
      while (ps2_clk_low === 1'b1 && inh < INH + 100) begin
         inh++;
         if (ps2_data_low) dl++;
         tick();
      end
      rel_cyc = cyc;
      check("inhibit_len", inh, INH);
      check("start_overlap", dl, 1);
      check("data_low_at_release", ps2_data_low, 1);
   endtask

   task automatic device_frame(input bit do_ack, input bit glitch, input int poke_edge,
                               input int abort_edge, output logic [9:0] seen);
      seen = '0;
      repeat (HP) tick();
      check("start_bit", ps2_data_in, 0);
      for (int k = 1; k <= 11; k++) begin
         dev_clk_low = 1'b1;
         for (int j = 0; j < HP; j++) begin
            if (k == poke_edge) begin
               tx_valid = (j == 0);
               tx_data  = 8'hAA;
            end
            tick();
         end
         if (k == abort_edge) return;
         if (k <= 10) seen[k-1] = ps2_data_in;
         dev_clk_low = 1'b0;
         if (k == 10) dev_data_low = do_ack;
         if (k == 11) dev_data_low = 1'b0;
         for (int j = 0; j < HP; j++) begin
            if (glitch && k >= 2 && k <= 8) dev_clk_low = (j >= 15 && j < 18);
            tick();
         end
      end
   endtask

   task automatic run_frame(input logic [7:0] d, input bit do_ack, input bit glitch,
                            input int poke_edge);
      logic [9:0] seen;
      int d0, e0, w;
      d0 = n_done;
      e0 = n_err;
      start_tx(d);
      device_frame(do_ack, glitch, poke_edge, 0, seen);
      w = 0;
      while (n_done == d0 && n_err == e0 && w < 300) begin
         tick();
         w++;
      end
      repeat (5) tick();
      check("frame_bits", seen, model_bits(d));
      check("done_pulses", n_done - d0, do_ack ? 1 : 0);
      check("error_pulses", n_err - e0, do_ack ? 0 : 1);
      check("busy_end", busy, 0);
      check("ready_end", tx_ready, 1);
      check("clk_released", ps2_clk_low, 0);
      check("data_released", ps2_data_low, 0);
   endtask

   initial begin
      logic [9:0] seen;
      logic [9:0] mb;
      int d0, e0, w;
      cyc = 0; n_done = 0; n_err = 0; n_bad = 0; err_cyc = 0; rel_cyc = 0;
      vectors = 0; miscompares = 0;
      reset_n = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
      dev_clk_low = 1'b0; dev_data_low = 1'b0;
      repeat (5) tick();
      check("rst_ready", tx_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_clk_low", ps2_clk_low, 0);
      check("rst_data_low", ps2_data_low, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      reset_n = 1'b1;
      repeat (20) tick();

      run_frame(8'hED, 1'b1, 1'b0, 0);
      run_frame(8'h07, 1'b1, 1'b0, 4);
      run_frame(8'h5A, 1'b0, 1'b0, 0);
      run_frame(8'h3C, 1'b1, 1'b1, 0);

      // device never clocks
      d0 = n_done;
      e0 = n_err;
      start_tx(8'h81);
      w = 0;
      while (n_err == e0 && w < TO + 200) begin
         tick();
         w++;
      end
      check("timeout_latency", err_cyc - rel_cyc, TO);
      check("timeout_clk", ps2_clk_low, 0);
      check("timeout_data", ps2_data_low, 0);
      check("timeout_ready", tx_ready, 1);
      check("timeout_no_done", n_done - d0, 0);
      repeat (10) tick();

      // reset during bit 4
      d0 = n_done;
      e0 = n_err;
      mb = model_bits(8'hE5);
      start_tx(8'hE5);
      device_frame(1'b1, 1'b0, 0, 5, seen);
      check("bit4_driven", ps2_data_low, !mb[4]);
      reset_n = 1'b0;
      #1;
      check("async_clk_rel", ps2_clk_low, 0);
      check("async_data_rel", ps2_data_low, 0);
      check("async_busy", busy, 0);
      dev_clk_low = 1'b0;
      dev_data_low = 1'b0;
      repeat (5) tick();
      reset_n = 1'b1;
      repeat (30) tick();
      check("reset_no_done", n_done - d0, 0);
      check("reset_no_error", n_err - e0, 0);
      run_frame(8'hFF, 1'b1, 1'b0, 0);

      for (int r = 0; r < 4; r++) begin
         run_frame(8'($urandom), 1'b1, 1'($urandom_range(0, 1)), 0);
      end

      check("pulse_rules", n_bad, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
